// File: rtl/rs_alu.sv
// rs_alu: 16-entry reservation station feeding the integer ALU, with two CDB wakeup ports.
// Optional macro RS_WAKEUP_ISSUE_EN: the select logic sees same-cycle CDB wakeups.
module rs_alu #(
    parameter int unsigned ROB_W = 4,
    parameter int unsigned OP_W  = 5,
    parameter int unsigned XLEN  = 32
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             flush_in,
    input  logic             disp_valid,
    output logic             disp_ready,
    input  logic [OP_W-1:0]  disp_op,
    input  logic [XLEN-1:0]  disp_vj,
    input  logic [XLEN-1:0]  disp_vk,
    input  logic [ROB_W-1:0] disp_qj,
    input  logic [ROB_W-1:0] disp_qk,
    input  logic [ROB_W-1:0] disp_dest,
    input  logic             cdb0_valid,
    input  logic [ROB_W-1:0] cdb0_tag,
    input  logic [XLEN-1:0]  cdb0_value,
    input  logic             cdb1_valid,
    input  logic [ROB_W-1:0] cdb1_tag,
    input  logic [XLEN-1:0]  cdb1_value,
    output logic             alu_valid,
    output logic [OP_W-1:0]  alu_op,
    output logic [XLEN-1:0]  alu_a,
    output logic [XLEN-1:0]  alu_b,
    output logic [ROB_W-1:0] alu_dest
);
    localparam int unsigned NUM_ENTRIES = 16;
    localparam int unsigned IDX_W       = 4;

    logic [NUM_ENTRIES-1:0] busy_q, busy_d;
    logic [OP_W-1:0]        op_q   [NUM_ENTRIES];
    logic [XLEN-1:0]        vj_q   [NUM_ENTRIES];
    logic [XLEN-1:0]        vk_q   [NUM_ENTRIES];
    logic [ROB_W-1:0]       qj_q   [NUM_ENTRIES];
    logic [ROB_W-1:0]       qk_q   [NUM_ENTRIES];
    logic [ROB_W-1:0]       dest_q [NUM_ENTRIES];

    logic [XLEN-1:0]        vj_w   [NUM_ENTRIES];
    logic [XLEN-1:0]        vk_w   [NUM_ENTRIES];
    logic [ROB_W-1:0]       qj_w   [NUM_ENTRIES];
    logic [ROB_W-1:0]       qk_w   [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] ready;

    logic             issue_found, alloc_found, disp_fire;
    logic [IDX_W-1:0] issue_idx, alloc_idx;
    logic [XLEN-1:0]  disp_vj_w, disp_vk_w;
    logic [ROB_W-1:0] disp_qj_w, disp_qk_w;

    // Wakeup: cdb0 takes precedence if both ports carry the same tag.
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            vj_w[i] = vj_q[i];
            qj_w[i] = qj_q[i];
            vk_w[i] = vk_q[i];
            qk_w[i] = qk_q[i];
            if (busy_q[i] && qj_q[i] != '0) begin
                if (cdb0_valid && cdb0_tag == qj_q[i]) begin
                    vj_w[i] = cdb0_value;
                    qj_w[i] = '0;
                end else if (cdb1_valid && cdb1_tag == qj_q[i]) begin
                    vj_w[i] = cdb1_value;
                    qj_w[i] = '0;
                end
            end
            if (busy_q[i] && qk_q[i] != '0) begin
                if (cdb0_valid && cdb0_tag == qk_q[i]) begin
                    vk_w[i] = cdb0_value;
                    qk_w[i] = '0;
                end else if (cdb1_valid && cdb1_tag == qk_q[i]) begin
                    vk_w[i] = cdb1_value;
                    qk_w[i] = '0;
                end
            end
`ifdef RS_WAKEUP_ISSUE_EN
            ready[i] = busy_q[i] && (qj_w[i] == '0) && (qk_w[i] == '0);
`else
            ready[i] = busy_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
`endif
        end
    end

    // Both encoders scan downward so the lowest matching index wins.
    always_comb begin
        issue_found = 1'b0;
        issue_idx   = '0;
        alloc_found = 1'b0;
        alloc_idx   = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (ready[i]) begin
                issue_found = 1'b1;
                issue_idx   = IDX_W'(i);
            end
            if (!busy_q[i]) begin
                alloc_found = 1'b1;
                alloc_idx   = IDX_W'(i);
            end
        end
    end

    assign disp_ready = alloc_found;
    assign disp_fire  = disp_valid && disp_ready && rdy_in && !flush_in;

    always_comb begin
        disp_vj_w = disp_vj;
        disp_qj_w = disp_qj;
        disp_vk_w = disp_vk;
        disp_qk_w = disp_qk;
        if (disp_qj != '0) begin
            if (cdb0_valid && cdb0_tag == disp_qj) begin
                disp_vj_w = cdb0_value;
                disp_qj_w = '0;
            end else if (cdb1_valid && cdb1_tag == disp_qj) begin
                disp_vj_w = cdb1_value;
                disp_qj_w = '0;
            end
        end
        if (disp_qk != '0) begin
            if (cdb0_valid && cdb0_tag == disp_qk) begin
                disp_vk_w = cdb0_value;
                disp_qk_w = '0;
            end else if (cdb1_valid && cdb1_tag == disp_qk) begin
                disp_vk_w = cdb1_value;
                disp_qk_w = '0;
            end
        end
    end

    // Dispatch targets a vacant slot, issue a busy one, so the two never collide.
    always_comb begin
        busy_d = busy_q;
        if (issue_found) busy_d[issue_idx] = 1'b0;
        if (disp_fire) busy_d[alloc_idx] = 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_q    <= '0;
            alu_valid <= 1'b0;
            alu_op    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_dest  <= '0;
        end else if (flush_in) begin
            busy_q    <= '0;
            alu_valid <= 1'b0;
        end else if (rdy_in) begin
            busy_q    <= busy_d;
            alu_valid <= issue_found;
            if (issue_found) begin
                alu_op   <= op_q[issue_idx];
                alu_a    <= vj_w[issue_idx];
                alu_b    <= vk_w[issue_idx];
                alu_dest <= dest_q[issue_idx];
            end
        end
    end

    // Payload needs no reset: busy gates every use of it.
    always_ff @(posedge clk_in) begin
        if (!rst_in && !flush_in && rdy_in) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (disp_fire && alloc_idx == IDX_W'(i)) begin
                    op_q[i]   <= disp_op;
                    vj_q[i]   <= disp_vj_w;
                    vk_q[i]   <= disp_vk_w;
                    qj_q[i]   <= disp_qj_w;
                    qk_q[i]   <= disp_qk_w;
                    dest_q[i] <= disp_dest;
                end else begin
                    vj_q[i] <= vj_w[i];
                    vk_q[i] <= vk_w[i];
                    qj_q[i] <= qj_w[i];
                    qk_q[i] <= qk_w[i];
                end
            end
        end
    end
endmodule
